// File: rtl/softmax_norm.sv
// softmax_norm: buffers one row of exp terms and accumulates their sum.
// It then emits prob = floor((term << 16) / sum) in Q0.16 for each term,
// one at a time, through a valid/ready output port.
// The division is a restoring divider producing one quotient bit per cycle.
// Optional build macro NORM_ROUND_EN: round to nearest instead of truncating.
//
// Handshakes: a term is taken on any rising edge where exp_valid && in_ready.
// A result is taken on any rising edge where prob_valid && prob_ready.
// prob/prob_idx stay stable while prob_valid is high and prob_ready is low.
module softmax_norm #(
   parameter int N = 16,
   parameter int W = 32,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exp_valid,
   input  logic [W-1:0]  exp,
   input  logic          exp_last,
   output logic          in_ready,
   output logic          prob_valid,
   input  logic          prob_ready,
   output logic [15:0]   prob,
   output logic [IW-1:0] prob_idx,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} state_t;

   localparam logic [IW:0] LAST_PTR = (IW+1)'(N - 1);

   state_t        state;
   logic [W-1:0]  term_buf [N];
   logic [IW:0]   wr_ptr;
   logic [IW-1:0] i;
   logic [31:0]   sum;
   logic [4:0]    cnt;
   logic [31:0]   r;
   logic [16:0]   s;
   logic [16:0]   q;

   logic          accept;
   logic          last_term;
   logic [32:0]   sum_wide;
   logic [31:0]   sum_add;
   logic [31:0]   buf_rd;
   logic [31:0]   r_in;
   logic [16:0]   s_in;
   logic [16:0]   q_in;
   logic [32:0]   t;
   logic          ge;
   logic [31:0]   r_nx;
   logic [16:0]   s_nx;
   logic [16:0]   q_nx;
   logic [17:0]   q_r;
   logic [15:0]   q_sat;

   assign accept    = exp_valid & in_ready;
   assign last_term = (({1'b0, i} + 1'b1) == wr_ptr);

   // Saturating row sum and one restoring-divider step.
   // At cnt 0 the step is seeded directly from the buffered term.
   always_comb begin
      sum_wide = {1'b0, sum} + 33'(exp);
      sum_add  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
      buf_rd   = 32'(term_buf[i]);
      // Every term is <= sum, so dividend bits above bit 16 leave only buf >> 1.
      r_in     = (cnt == 5'd0) ? (buf_rd >> 1) : r;
      s_in     = (cnt == 5'd0) ? {buf_rd[0], 16'h0000} : s;
      q_in     = (cnt == 5'd0) ? 17'd0 : q;
      t        = {r_in, s_in[16]};
      ge       = (t >= {1'b0, sum});
      r_nx     = ge ? 32'(t - {1'b0, sum}) : t[31:0];
      s_nx     = {s_in[15:0], 1'b0};
      q_nx     = {q_in[15:0], ge};
`ifdef NORM_ROUND_EN
      q_r      = {1'b0, q_nx} + {17'd0, ({r_nx, 1'b0} >= {1'b0, sum})};
`else
      q_r      = {1'b0, q_nx};
`endif
      q_sat    = (q_r[17:16] != 2'b00) ? 16'hFFFF : q_r[15:0];
   end

   // Term storage. Reset does not clear it because stale entries are never read.
   always_ff @(posedge clk) begin
      if (accept) term_buf[wr_ptr[IW-1:0]] <= exp;
   end

   // Row control FSM, divider registers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         prob_valid <= 1'b0;
         prob       <= 16'h0000;
         prob_idx   <= '0;
         done       <= 1'b0;
         sum        <= 32'd0;
         wr_ptr     <= '0;
         i          <= '0;
         cnt        <= 5'd0;
         r          <= 32'd0;
         s          <= 17'd0;
         q          <= 17'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, ACC: begin
               in_ready <= 1'b1;
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  sum    <= sum_add;
                  if (exp_last || (wr_ptr == LAST_PTR)) begin
                     state    <= DIV;
                     in_ready <= 1'b0;
                     cnt      <= 5'd0;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            DIV: begin
               if (sum == 32'd0) begin
                  // All terms are zero, so skip the divider.
                  prob       <= 16'h0000;
                  prob_idx   <= i;
                  prob_valid <= 1'b1;
                  state      <= OUT;
               end else begin
                  r   <= r_nx;
                  s   <= s_nx;
                  q   <= q_nx;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd16) begin
                     prob       <= q_sat;
                     prob_idx   <= i;
                     prob_valid <= 1'b1;
                     state      <= OUT;
                  end
               end
            end
            OUT: begin
               if (prob_ready) begin
                  prob_valid <= 1'b0;
                  if (last_term) begin
                     done     <= 1'b1;
                     state    <= IDLE;
                     in_ready <= 1'b1;
                     wr_ptr   <= '0;
                     sum      <= 32'd0;
                     i        <= '0;
                  end else begin
                     i     <= i + 1'b1;
                     state <= DIV;
                     cnt   <= 5'd0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: directed vector table, a reset-abort sequence and random rows.
// Expected values come from a behavioural model of the row arithmetic.
module tb_softmax_norm;

   localparam int N = 16;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_d = 32'd0;
   logic        exp_last = 1'b0;
   logic        prob_ready = 1'b0;
   logic        in_ready;
   logic        prob_valid;
   logic [15:0] prob;
   logic [3:0]  prob_idx;
   logic        done;

   softmax_norm #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp(exp_d), .exp_last(exp_last),
      .in_ready(in_ready), .prob_valid(prob_valid), .prob_ready(prob_ready),
      .prob(prob), .prob_idx(prob_idx), .done(done)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Count done pulses, sampled away from the active edge.
   int done_cnt = 0;
   always @(negedge clk) if (done) done_cnt++;

   int errors = 0;
   int checks = 0;
   int mark = 0;
   logic [19:0] exp_q[$];
   logic [31:0] row_t [16];
   bit          row_zero;

   typedef struct {
      int          len;
      bit          use_last;
      int          stall0;
      logic [31:0] t [16];
      logic [15:0] p [16];
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: exact rational arithmetic on the saturated row sum.
   function automatic logic [15:0] ref_prob(input logic [31:0] term, input logic [31:0] s);
      longint unsigned num, qv, rem;
      if (s == 32'd0) return 16'h0000;
      num = longint'(term) * 65536;
      qv  = num / s;
      rem = num % s;
`ifdef NORM_ROUND_EN
      if (2 * rem >= longint'(s)) qv++;
`endif
      if (qv > 65535) qv = 65535;
      return qv[15:0];
   endfunction

   task automatic model_row(input int len);
      longint unsigned tot = 0;
      logic [31:0] s;
      for (int k = 0; k < len; k++) tot += row_t[k];
      s = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
      row_zero = (s == 32'd0);
      for (int k = 0; k < len; k++) exp_q.push_back({4'(k), ref_prob(row_t[k], s)});
   endtask

   // Driver: present one term and wait (bounded) for it to be accepted.
   task automatic send_term(input logic [31:0] v, input bit l);
      int w = 0;
      exp_valid = 1'b1; exp_d = v; exp_last = l;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin
         check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      end else begin
         mark = cyc;
         @(posedge clk); #1;
      end
      exp_valid = 1'b0; exp_last = 1'b0;
   endtask

   task automatic send_row(input int len, input bit use_last);
      for (int k = 0; k < len; k++) send_term(row_t[k], use_last && (k == len - 1));
   endtask

   // Receiver: wait for a result, compare against the scoreboard, optionally stall.
   task automatic recv_one(input int stall, input bit junk, input int want_lat);
      int w = 0;
      logic [19:0] e;
      logic [15:0] p0;
      logic [3:0]  i0;
      while (!prob_valid && w < 100) begin @(posedge clk); #1; w++; end
      check("prob_valid_wait", {31'd0, prob_valid}, 32'd1);
      if (!prob_valid) return;
      check("latency", cyc - mark, want_lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
      check("prob", {16'd0, prob}, {16'd0, e[15:0]});
      check("prob_idx", {28'd0, prob_idx}, {28'd0, e[19:16]});
      p0 = prob; i0 = prob_idx;
      for (int k = 0; k < stall; k++) begin
         if (junk) begin exp_valid = 1'b1; exp_d = $urandom; end
         @(posedge clk); #1;
         if (junk) begin
            check("stall_prob", {16'd0, prob}, {16'd0, p0});
            check("stall_idx", {28'd0, prob_idx}, {28'd0, i0});
            check("stall_valid", {31'd0, prob_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         end
      end
      exp_valid = 1'b0;
      prob_ready = 1'b1;
      mark = cyc;
      @(posedge clk); #1;
      prob_ready = 1'b0;
   endtask

   task automatic recv_row(input int len, input int stall0, input int stall_max);
      int d0 = done_cnt;
      for (int k = 0; k < len; k++) begin
         if (k == 0 && stall0 > 0) recv_one(stall0, 1'b1, row_zero ? 2 : 18);
         else recv_one($urandom_range(0, stall_max), 1'b0, row_zero ? 2 : 18);
      end
      check("done_pulse", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      check("done_low", {31'd0, done}, 32'd0);
      check("done_count", done_cnt, d0 + 1);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int seen;
      // Directed vector table.
      foreach (vecs[v]) begin
         vecs[v].len = 0; vecs[v].use_last = 1'b1; vecs[v].stall0 = 0;
         foreach (vecs[v].t[k]) begin vecs[v].t[k] = 32'd0; vecs[v].p[k] = 16'h0000; end
      end
      vecs[0].len = 4;
      for (int k = 0; k < 4; k++) begin vecs[0].t[k] = 32'd1; vecs[0].p[k] = 16'h4000; end
      vecs[1].len = 2; vecs[1].t[0] = 32'd1; vecs[1].t[1] = 32'd2; vecs[1].p[0] = 16'h5555;
`ifdef NORM_ROUND_EN
      vecs[1].p[1] = 16'hAAAB;
`else
      vecs[1].p[1] = 16'hAAAA;
`endif
      vecs[2].len = 1; vecs[2].t[0] = 32'd7; vecs[2].p[0] = 16'hFFFF;
      vecs[3].len = 3;
      vecs[4].len = 3; vecs[4].stall0 = 10;
      vecs[4].t[0] = 32'd5; vecs[4].t[1] = 32'd6; vecs[4].t[2] = 32'd7;
      vecs[4].p[0] = 16'h471C; vecs[4].p[1] = 16'h5555; vecs[4].p[2] = 16'h638E;

      // Reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_prob_valid", {31'd0, prob_valid}, 32'd0);
      check("rst_prob", {16'd0, prob}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

      // Table-driven rows.
      foreach (vecs[v]) begin
         for (int k = 0; k < vecs[v].len; k++) begin
            row_t[k] = vecs[v].t[k];
            exp_q.push_back({4'(k), vecs[v].p[k]});
         end
         row_zero = 1'b1;
         for (int k = 0; k < vecs[v].len; k++) if (row_t[k] != 0) row_zero = 1'b0;
         send_row(vecs[v].len, vecs[v].use_last);
         recv_row(vecs[v].len, vecs[v].stall0, 0);
      end

      // Reset in the middle of DIV on a 16-term row.
      for (int k = 0; k < 16; k++) row_t[k] = $urandom_range(1, 5000);
      send_row(16, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      check("abort_prob_valid", {31'd0, prob_valid}, 32'd0);
      check("abort_prob", {16'd0, prob}, 32'd0);
      check("abort_prob_idx", {28'd0, prob_idx}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_in_ready_release", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (prob_valid || done) seen++;
      end
      check("abort_no_stale_output", seen, 0);
      exp_q.delete();
      row_t[0] = 32'd3; row_t[1] = 32'd9;
      model_row(2);
      send_row(2, 1'b1);
      recv_row(2, 0, 1);

      // Random rows against the behavioural model.
      for (int r = 0; r < 12; r++) begin
         int len = $urandom_range(1, 16);
         int mode = $urandom_range(0, 2);
         for (int k = 0; k < len; k++)
            row_t[k] = (mode == 0) ? $urandom_range(0, 1000) :
                       (mode == 1) ? $urandom : $urandom_range(0, 3);
         model_row(len);
         send_row(len, (len < 16) ? 1'b1 : 1'($urandom_range(0, 1)));
         recv_row(len, 0, 2);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
